dmem_line_server: RTL and testbench

//  Backing data-memory responder for the set-associative data cache: services whole-line fill (read)
//  and writeback (write) requests over a valid/done handshake. Models multi-cycle main-memory latency,

---
 rtl/dmem_line_server_pkg.sv | 19 +
 rtl/dmem_line_server_if.sv | 23 ++
 rtl/dmem_line_server_bram_sp.sv | 20 ++
 rtl/dmem_line_server.sv | 129 ++++++++++++
 tb/tb_dmem_line_server.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/dmem_line_server_pkg.sv
// Shared types and constants for the data-memory line server.
// The range-check build option (DMEM_RANGE_CHK_EN) is selected in dmem_line_server.sv.
package dmem_line_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        XFER,
        DONE
    } state_t;

    localparam int unsigned DEF_WORDS_PER_LINE = 4;

    // Word 0 sits in bits [31:0].
    typedef logic [DEF_WORDS_PER_LINE-1:0][31:0] line_t;

    localparam logic [31:0] ERR_FILL_WORD = 32'hDEADBEEF;

endpackage

// File: rtl/dmem_line_server_if.sv
// Line request/response bus between the D-cache (master) and the line server (slave).
interface dmem_line_server_if #(
    parameter int unsigned WORDS_PER_LINE = dmem_line_pkg::DEF_WORDS_PER_LINE
);
    logic                        REQ_VALID;
    logic                        REQ_WE;
    logic [31:0]                 REQ_ADDR;
    logic [32*WORDS_PER_LINE-1:0] REQ_WDATA;
    logic                        BUSY;
    logic                        RSP_DONE;
    logic [32*WORDS_PER_LINE-1:0] RSP_RDATA;
    logic                        RSP_ERR;

    modport master (
        output REQ_VALID, REQ_WE, REQ_ADDR, REQ_WDATA,
        input  BUSY, RSP_DONE, RSP_RDATA, RSP_ERR
    );

    modport slave (
        input  REQ_VALID, REQ_WE, REQ_ADDR, REQ_WDATA,
        output BUSY, RSP_DONE, RSP_RDATA, RSP_ERR
    );
endinterface

// File: rtl/dmem_line_server_bram_sp.sv
// Single-port BRAM with one-cycle synchronous read (read-first), inferred.
module dmem_bram_sp #(
    parameter int unsigned DEPTH_WORDS = 16384,
    parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic          we,
    input  logic [31:0]   din,
    output logic [31:0]   dout
);
    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= din;
        end
        dout <= mem[addr];
    end
endmodule

// File: rtl/dmem_line_server.sv
// Multi-cycle line fill/writeback responder in front of a single-port BRAM.
// Build option: define DMEM_RANGE_CHK_EN to flag out-of-range word addresses via RSP_ERR.
module dmem_line_server
    import dmem_line_pkg::*;
#(
    parameter int unsigned WORDS_PER_LINE = DEF_WORDS_PER_LINE,
    parameter int unsigned DEPTH_WORDS    = 16384,
    parameter int unsigned LATENCY        = 4
) (
    input  logic               MEM_CLK,
    input  logic               RST,
    dmem_line_server_if.slave  bus
);
    localparam int unsigned OFF_W = $clog2(WORDS_PER_LINE);
    localparam int unsigned AW    = $clog2(DEPTH_WORDS);
    localparam int unsigned LAT_W = $clog2(LATENCY + 1);
    localparam int unsigned CNT_W = $clog2(WORDS_PER_LINE + 1);

    state_t                             state;
    logic [LAT_W-1:0]                   lat_cnt;
    logic [CNT_W-1:0]                   word_cnt;
    logic                               we_q;
    logic                               err_q;
    logic [AW-OFF_W-1:0]                line_q;
    logic [WORDS_PER_LINE-1:0][31:0]    wline_q;
    logic [WORDS_PER_LINE-1:0][31:0]    rline_q;
    logic                               busy_q;
    logic                               done_q;
    logic                               rsp_err_q;

    logic [AW-1:0]                      ram_addr;
    logic                               ram_we;
    logic [31:0]                        ram_din;
    logic [31:0]                        ram_dout;
    logic [OFF_W-1:0]                   word_idx;
    logic [OFF_W-1:0]                   cap_idx;
    logic                               range_err;
    logic                               unused_addr;

`ifdef DMEM_RANGE_CHK_EN
    assign range_err = ({2'b00, bus.REQ_ADDR[31:2]} >= 32'(DEPTH_WORDS));
`else
    assign range_err = 1'b0;
`endif
    assign unused_addr = ^bus.REQ_ADDR;

    // Offset bits come straight from the counter, so a line never crosses its aligned base.
    assign word_idx = word_cnt[OFF_W-1:0];
    assign cap_idx  = OFF_W'(word_cnt - CNT_W'(1));
    assign ram_addr = {line_q, word_idx};
    assign ram_din  = wline_q[word_idx];
    // Gated by RST so a write in the abort cycle never lands.
    assign ram_we   = (state == XFER) && we_q && !err_q && !RST
                      && (word_cnt < CNT_W'(WORDS_PER_LINE));

    dmem_bram_sp #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_bram (
        .clk  (MEM_CLK),
        .addr (ram_addr),
        .we   (ram_we),
        .din  (ram_din),
        .dout (ram_dout)
    );

    always_ff @(posedge MEM_CLK) begin
        if (RST) begin
            state     <= IDLE;
            lat_cnt   <= '0;
            word_cnt  <= '0;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
            line_q    <= '0;
            wline_q   <= '0;
            rline_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rsp_err_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.REQ_VALID) begin
                        we_q      <= bus.REQ_WE;
                        err_q     <= range_err;
                        line_q    <= bus.REQ_ADDR[2+OFF_W +: AW-OFF_W];
                        wline_q   <= bus.REQ_WDATA;
                        rline_q   <= '0;
                        rsp_err_q <= 1'b0;
                        lat_cnt   <= '0;
                        busy_q    <= 1'b1;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (lat_cnt == LAT_W'(LATENCY - 1)) begin
                        lat_cnt  <= '0;
                        word_cnt <= '0;
                        state    <= XFER;
                    end else begin
                        lat_cnt <= lat_cnt + LAT_W'(1);
                    end
                end
                XFER: begin
                    word_cnt <= word_cnt + CNT_W'(1);
                    // Read data trails its address by one cycle, hence the extra XFER cycle.
                    if (!we_q && (word_cnt != '0)) begin
                        rline_q[cap_idx] <= err_q ? ERR_FILL_WORD : ram_dout;
                    end
                    if (word_cnt == CNT_W'(we_q ? WORDS_PER_LINE - 1 : WORDS_PER_LINE)) begin
                        done_q    <= 1'b1;
                        rsp_err_q <= err_q;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.BUSY      = busy_q;
    assign bus.RSP_DONE  = done_q;
    assign bus.RSP_RDATA = rline_q;
    assign bus.RSP_ERR   = rsp_err_q;
endmodule

// File: tb/tb_dmem_line_server.sv
// Directed self-checking bench for dmem_line_server (WORDS_PER_LINE=4, DEPTH_WORDS=16384, LATENCY=4).
module tb_dmem_line_server;
    import dmem_line_pkg::*;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    dmem_line_server_if #(.WORDS_PER_LINE(4)) bus ();

    dmem_line_server #(
        .WORDS_PER_LINE (4),
        .DEPTH_WORDS    (16384),
        .LATENCY        (4)
    ) dut (
        .MEM_CLK (clk),
        .RST     (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drives one request for a single cycle, returns the response and cycles from accept to RSP_DONE.
    task automatic do_req(input logic we, input logic [31:0] addr, input line_t wdata,
                          output line_t rdata, output logic err, output int lat);
        @(negedge clk);
        bus.REQ_VALID = 1'b1;
        bus.REQ_WE    = we;
        bus.REQ_ADDR  = addr;
        bus.REQ_WDATA = wdata;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                check_eq("busy_after_accept", 128'(bus.BUSY), 128'(1));
                check_eq("rdata_cleared", bus.RSP_RDATA, '0);
                bus.REQ_VALID = 1'b0;
                bus.REQ_WE    = ~we;
                bus.REQ_ADDR  = addr ^ 32'h0000_0040;
                bus.REQ_WDATA = ~wdata;
            end
        end while (!bus.RSP_DONE && lat < 40);
        rdata = bus.RSP_RDATA;
        err   = bus.RSP_ERR;
    endtask

    localparam line_t L0 = 128'hA0A0A0A3_A0A0A0A2_A0A0A0A1_A0A0A0A0;
    localparam line_t L1 = 128'h44444444_33333333_22222222_11111111;
    localparam line_t LO = 128'h0D0D0D03_0D0D0D02_0D0D0D01_0D0D0D00;
    localparam line_t LN = 128'h5E5E5E53_5E5E5E52_5E5E5E51_5E5E5E50;
    localparam line_t L3 = 128'hCAFE0003_CAFE0002_CAFE0001_CAFE0000;

    initial begin
        line_t rd;
        line_t exp_line;
        logic  err;
        int    lat;
        int    pulses;
        int    first;
        int    second;

        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        bus.REQ_VALID = 1'b0;
        bus.REQ_WE    = 1'b0;
        bus.REQ_ADDR  = '0;
        bus.REQ_WDATA = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_busy", 128'(bus.BUSY), 128'(0));
        check_eq("rst_done", 128'(bus.RSP_DONE), 128'(0));
        check_eq("rst_rdata", bus.RSP_RDATA, '0);
        check_eq("rst_err", 128'(bus.RSP_ERR), 128'(0));
        rst = 1'b0;

        do_req(1'b1, 32'h0000_0100, L1, rd, err, lat);
        check_eq("wr100_latency", 128'(lat), 128'(9));
        check_eq("wr100_err", 128'(err), 128'(0));
        check_eq("wr100_rdata_zero", rd, '0);

        do_req(1'b0, 32'h0000_010C, '0, rd, err, lat);
        check_eq("rd10c_latency", 128'(lat), 128'(10));
        check_eq("rd10c_line", rd, L1);
        check_eq("rd10c_word0", 128'(rd[0]), 128'(32'h11111111));
        check_eq("rd10c_err", 128'(err), 128'(0));

        do_req(1'b1, 32'h0000_0000, L0, rd, err, lat);
        check_eq("wr000_latency", 128'(lat), 128'(9));

        do_req(1'b1, 32'h0000_0200, LO, rd, err, lat);
        check_eq("wr200_latency", 128'(lat), 128'(9));

        // Abort a writeback with RST during XFER cycle 2 (accept cycle + 7).
        @(negedge clk);
        bus.REQ_VALID = 1'b1;
        bus.REQ_WE    = 1'b1;
        bus.REQ_ADDR  = 32'h0000_0200;
        bus.REQ_WDATA = LN;
        pulses = 0;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            bus.REQ_VALID = 1'b0;
            if (bus.RSP_DONE) pulses++;
        end
        rst = 1'b1;
        @(negedge clk);
        check_eq("abort_busy", 128'(bus.BUSY), 128'(0));
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.RSP_DONE) pulses++;
        end
        check_eq("abort_no_done", 128'(pulses), 128'(0));

        exp_line = {LO[3], LO[2], LN[1], LN[0]};
        do_req(1'b0, 32'h0000_0200, '0, rd, err, lat);
        check_eq("rd200_partial", rd, exp_line);

        // REQ_VALID held through RSP_DONE: back-to-back accepts one cycle apart.
        @(negedge clk);
        bus.REQ_VALID = 1'b1;
        bus.REQ_WE    = 1'b1;
        bus.REQ_ADDR  = 32'h0000_0300;
        bus.REQ_WDATA = L3;
        pulses = 0;
        first  = 0;
        second = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (bus.RSP_DONE) begin
                pulses++;
                if (first == 0) first = c;
                else if (second == 0) second = c;
            end
            if (first != 0 && c == first + 1)
                check_eq("held_idle_gap", 128'(bus.BUSY), 128'(0));
            if (first != 0 && c == first + 2)
                check_eq("held_reaccept", 128'(bus.BUSY), 128'(1));
            if (second != 0) bus.REQ_VALID = 1'b0;
        end
        bus.REQ_VALID = 1'b0;
        check_eq("held_first_done", 128'(first), 128'(9));
        check_eq("held_second_gap", 128'(second - first), 128'(10));
        check_eq("held_pulses", 128'(pulses), 128'(2));

        do_req(1'b0, 32'h0000_0304, '0, rd, err, lat);
        check_eq("rd300_line", rd, L3);

        // Single-cycle REQ_VALID: exactly one RSP_DONE and nothing afterwards.
        do_req(1'b1, 32'h0000_0400, L1, rd, err, lat);
        check_eq("pulse_latency", 128'(lat), 128'(9));
        pulses = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (bus.RSP_DONE) pulses++;
        end
        check_eq("pulse_no_extra_done", 128'(pulses), 128'(0));

        do_req(1'b0, 32'h0010_0000, '0, rd, err, lat);
        check_eq("range_latency", 128'(lat), 128'(10));
`ifdef DMEM_RANGE_CHK_EN
        check_eq("range_err", 128'(err), 128'(1));
        check_eq("range_fill", rd, {4{32'hDEADBEEF}});
`else
        check_eq("range_err", 128'(err), 128'(0));
        check_eq("range_alias", rd, L0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
